stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- Hardware operand stack for the multicycle stack processor; responder to the controller's push/pop/top command strobes.
- Holds operands in a register-file LIFO and presents a registered data output for the datapath's A register and ALU.
- Reports full/empty status, occupancy, and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries; must be a power of two, at least 2.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- push  input  1  write d_in as the new top entry this cycle.
- pop  input  1  remove the top entry this cycle; its value is captured into d_out.
- top  input  1  copy the top entry into d_out without removing it.
- d_in  input  WIDTH  data to push.
- clr_err  input  1  synchronous clear of the sticky error flags.
- d_out  output  WIDTH  registered read data.
- count  output  AW+1  current number of entries (0..DEPTH).
- full  output  1  high when count==DEPTH (combinational from count).
- empty  output  1  high when count==0 (combinational from count).
- ovf  output  1  sticky overflow flag.
- udf  output  1  sticky underflow flag.

Behaviour:
- Storage is DEPTH x WIDTH registers. sp = count; the top entry is mem[sp-1].
- Reset (rst==0 at the edge): count=0, d_out=0, ovf=0, udf=0. Memory contents are not cleared. Reset takes priority over every command, including one in progress.
- All updates take effect on the rising edge. d_out is only ever updated by a pop or top command, or by reset; otherwise it holds its value.
- Read latency is 1 cycle: a value captured on edge N is stable for the whole cycle after N.
- The commands are decoded with push, pop and top combined, in this priority order:
  - push & pop, count>0: replace the top. mem[sp-1]<=d_in; d_out<=old mem[sp-1]; count unchanged.
  - push & pop, count==0: behaves as push alone. udf is not set.
  - push only (top is ignored when combined with push), count<DEPTH: mem[sp]<=d_in; count<=count+1.
  - push only, count==DEPTH: no write; count unchanged; ovf<=1.
  - pop only (top is ignored when combined with pop), count>0: d_out<=mem[sp-1]; count<=count-1.
  - pop only, count==0: d_out<=0; count stays 0; udf<=1.
  - top only, count>0: d_out<=mem[sp-1]; count unchanged.
  - top only, count==0: d_out<=0; udf<=1.
  - No command: hold all state.
- Sticky flags:
  - ovf and udf stay set until clr_err or reset.
  - If clr_err coincides with a new error in the same cycle, the new error wins and the flag stays 1.
- Datapath timing contract with the controller:
  - top in ID, then pop in PNR1: A loads the d_out value captured by top; the entry is removed at the PNR1 edge.
  - A second pop in RT1: d_out holds the second operand from RT2 onward.
- Pointer arithmetic uses AW+1 bits, so count never wraps. The pointer and memory index never leave 0..DEPTH-1.
- No combinational path exists from push, pop or top to d_out.

Test Plan:
- Reset, then idle -> count=0, empty=1, full=0, d_out=0, ovf=0, udf=0.
- Push 0x11, 0x22, 0x33; then top -> count=3; d_out=0x33 one cycle after top; count unchanged.
- From [0x11,0x22,0x33]: pop, pop -> d_out=0x33 then 0x22; count=1; then push & pop with d_in=0x5A -> d_out=0x11, count=1, and a following top gives 0x5A.
- Push DEPTH=16 values, then push 0xFF -> full=1, count=16, ovf=1; a top still returns the 16th value, not 0xFF; clr_err -> ovf=0.
- Pop on empty -> d_out=0, udf=1, count=0; clr_err asserted together with another empty pop -> udf stays 1.
- Push 3 values, then assert rst=0 during a push -> count=0 and d_out=0 after the edge; the push is discarded.

Source files
------------

// File: rtl/stack_unit.sv
// Operand stack: register-file LIFO with registered read data,
// occupancy, full/empty status and sticky overflow/underflow flags.
// Ports: clk, rst (sync, active-low); push/pop/top strobes, d_in,
// clr_err in; d_out, count, full, empty, ovf, udf out.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             top,
  input  logic [WIDTH-1:0] d_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] d_out,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             we;
  logic [AW-1:0]    wa;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    nxt_idx;
  logic             is_full;
  logic             is_empty;

  assign is_full  = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);
  // Index math is truncated to AW bits; only used when legal.
  assign top_idx  = AW'(count_q - 1'b1);
  assign nxt_idx  = count_q[AW-1:0];

  always_comb begin
    count_d = count_q;
    d_out_d = d_out_q;
    // A new error in this cycle overrides the clear below.
    ovf_d   = ovf_q & ~clr_err;
    udf_d   = udf_q & ~clr_err;
    we      = 1'b0;
    wa      = nxt_idx;
    unique case (1'b1)
      push && pop: begin
        we = 1'b1;
        if (is_empty) begin
          count_d = count_q + 1'b1;
        end else begin
          wa      = top_idx;
          d_out_d = mem_q[top_idx];
        end
      end
      push && !pop: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      !push && pop: begin
        if (is_empty) begin
          d_out_d = '0;
          udf_d   = 1'b1;
        end else begin
          d_out_d = mem_q[top_idx];
          count_d = count_q - 1'b1;
        end
      end
      !push && !pop && top: begin
        if (is_empty) begin
          d_out_d = '0;
          udf_d   = 1'b1;
        end else begin
          d_out_d = mem_q[top_idx];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      d_out_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      d_out_q <= d_out_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is not reset, but a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && we) begin
      mem_q[wa] <= d_in;
    end
  end

  assign d_out = d_out_q;
  assign count = count_q;
  assign full  = is_full;
  assign empty = is_empty;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed steps plus a random stretch, with a
// reference LIFO feeding an expected-result queue checked each cycle.
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       top = 1'b0;
  logic [7:0] d_in = '0;
  logic       clr_err = 1'b0;
  logic [7:0] d_out;
  logic [4:0] count;
  logic       full, empty, ovf, udf;

  stack_unit #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .top(top),
    .d_in(d_in), .clr_err(clr_err), .d_out(d_out), .count(count),
    .full(full), .empty(empty), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dout;
    logic [4:0] cnt;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl[$];
  logic [7:0] m_dout = '0;
  bit         m_ovf = 0;
  bit         m_udf = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic op(input bit p, input bit po, input bit t,
                    input logic [7:0] d, input bit c, input bit r = 1);
    exp_t e;
    @(negedge clk);
    push = p; pop = po; top = t; d_in = d; clr_err = c; rst = r;
    if (!r) begin
      mdl.delete();
      m_dout = '0; m_ovf = 0; m_udf = 0;
    end else begin
      if (c) begin m_ovf = 0; m_udf = 0; end
      if (p && po) begin
        if (mdl.size() > 0) begin
          m_dout = mdl[mdl.size()-1];
          mdl[mdl.size()-1] = d;
        end else mdl.push_back(d);
      end else if (p) begin
        if (mdl.size() < 16) mdl.push_back(d);
        else m_ovf = 1;
      end else if (po) begin
        if (mdl.size() > 0) m_dout = mdl.pop_back();
        else begin m_dout = '0; m_udf = 1; end
      end else if (t) begin
        if (mdl.size() > 0) m_dout = mdl[mdl.size()-1];
        else begin m_dout = '0; m_udf = 1; end
      end
    end
    e.dout = m_dout;
    e.cnt  = 5'(mdl.size());
    e.ovf  = m_ovf;
    e.udf  = m_udf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    push = 0; pop = 0; top = 0; clr_err = 0; rst = 1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("d_out", 32'(d_out), 32'(e.dout));
      chk("count", 32'(count), 32'(e.cnt));
      chk("ovf", 32'(ovf), 32'(e.ovf));
      chk("udf", 32'(udf), 32'(e.udf));
      chk("full", 32'(full), 32'(e.cnt == 5'd16));
      chk("empty", 32'(empty), 32'(e.cnt == 5'd0));
    end
  endtask

  initial begin
    op(0, 0, 0, 8'h00, 0, 0);
    op(0, 0, 0, 8'h00, 0, 0);
    op(0, 0, 0, 8'h00, 0);
    chk("rst_d_out", 32'(d_out), 0);
    chk("rst_empty", 32'(empty), 1);

    op(1, 0, 0, 8'h11, 0);
    op(1, 0, 0, 8'h22, 0);
    op(1, 0, 0, 8'h33, 0);
    op(0, 0, 1, 8'h00, 0);
    chk("top_val", 32'(d_out), 32'h33);
    chk("top_cnt", 32'(count), 3);
    op(0, 0, 0, 8'h00, 0);
    chk("hold_val", 32'(d_out), 32'h33);

    op(0, 1, 0, 8'h00, 0);
    chk("pop1", 32'(d_out), 32'h33);
    op(0, 1, 1, 8'h00, 0);
    chk("pop2", 32'(d_out), 32'h22);
    chk("pop_cnt", 32'(count), 1);
    op(1, 1, 0, 8'h5A, 0);
    chk("repl_val", 32'(d_out), 32'h11);
    chk("repl_cnt", 32'(count), 1);
    op(0, 0, 1, 8'h00, 0);
    chk("repl_top", 32'(d_out), 32'h5A);
    op(0, 1, 0, 8'h00, 0);

    for (int i = 0; i < 16; i++) op(1, 0, 0, 8'(8'hA0 + i), 0);
    op(1, 0, 1, 8'hFF, 0);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_cnt", 32'(count), 16);
    op(0, 0, 1, 8'h00, 0);
    chk("ovf_top", 32'(d_out), 32'hAF);
    op(0, 0, 0, 8'h00, 1);
    chk("ovf_clr", 32'(ovf), 0);

    for (int i = 0; i < 16; i++) op(0, 1, 0, 8'h00, 0);
    op(0, 1, 0, 8'h00, 0);
    chk("udf_flag", 32'(udf), 1);
    chk("udf_dout", 32'(d_out), 0);
    op(0, 1, 0, 8'h00, 1);
    chk("udf_sticky", 32'(udf), 1);
    op(0, 0, 0, 8'h00, 1);
    chk("udf_clr", 32'(udf), 0);
    op(1, 1, 0, 8'h44, 0);
    chk("pp_empty_udf", 32'(udf), 0);
    chk("pp_empty_cnt", 32'(count), 1);
    op(0, 0, 1, 8'h00, 0);
    chk("pp_empty_top", 32'(d_out), 32'h44);

    op(1, 0, 0, 8'h01, 0);
    op(1, 0, 0, 8'h02, 0);
    op(1, 0, 0, 8'h03, 0);
    op(1, 0, 0, 8'h77, 0, 0);
    chk("rst_push_cnt", 32'(count), 0);
    chk("rst_push_dout", 32'(d_out), 0);

    for (int i = 0; i < 80; i++)
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 8'($urandom),
         ($urandom_range(0, 7) == 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
